// File: rtl/l2_mem_ctrl.sv
// L2-to-main-memory controller: accepts one line request at a time and issues ACT, a wrapped CAS burst and PRE.
// Build option: define OPEN_PAGE_EN to leave the row open after a burst (open-page policy).
module l2_mem_ctrl #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ROW_W     = 12,
    parameter int unsigned COL_W     = 10,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned T_RCD     = 2,
    parameter int unsigned T_CAS     = 2,
    parameter int unsigned T_RP      = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_stb_i,
    input  logic                     req_we_i,
    input  logic [ADDR_W-1:0]        req_addr_i,
    output logic                     req_ack_o,
    output logic                     busy_o,
    output logic                     wdata_rdy_o,
    input  logic [DATA_W-1:0]        req_wdata_i,
    output logic                     rd_valid_o,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic [((ROW_W > COL_W) ? ROW_W : COL_W)-1:0] mem_addr_o,
    output logic                     mem_cs_n_o,
    output logic                     mem_ras_n_o,
    output logic                     mem_cas_n_o,
    output logic                     mem_we_n_o,
    output logic [DATA_W-1:0]        mem_dq_out_o,
    output logic                     mem_dq_oe_o,
    input  logic [DATA_W-1:0]        mem_dq_in_i
);
    localparam int unsigned MA_W    = (ROW_W > COL_W) ? ROW_W : COL_W;
    localparam int unsigned RC_W    = ROW_W + COL_W;
    localparam int unsigned BEAT_W  = $clog2(BURST_LEN);
    localparam int unsigned T_MAX0  = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int unsigned T_MAX   = (T_MAX0 > (T_CAS + 1)) ? T_MAX0 : (T_CAS + 1);
    localparam int unsigned TCNT_W  = $clog2(T_MAX + 1);

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_DESEL = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE, S_ACT, S_RCD, S_BURST, S_DRAIN, S_PRE, S_RP
    } state_e;

`ifdef OPEN_PAGE_EN
    localparam state_e S_AFTER_DRAIN = S_IDLE;
    localparam state_e S_AFTER_RP    = S_ACT;
`else
    localparam state_e S_AFTER_DRAIN = S_PRE;
    localparam state_e S_AFTER_RP    = S_IDLE;
`endif

    state_e              state_q, state_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                we_q, we_d;
    logic [RC_W-1:0]     addr_q, addr_d;
    logic                accept_c;

    logic                ack_q, ack_d;
    logic                busy_q, busy_d;
    logic                wdata_rdy_q, wdata_rdy_d;
    logic                dq_oe_q, dq_oe_d;
    logic [3:0]          cmd_q, cmd_d;
    logic [MA_W-1:0]     mem_addr_q, mem_addr_d;
    logic [BEAT_W-1:0]   col_lo_c;

    logic [T_CAS-1:0]    rd_pipe_q;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                is_read_c;

`ifdef OPEN_PAGE_EN
    logic [ROW_W-1:0]    open_row_q;
    logic                open_vld_q;
`endif

    if (ADDR_W > RC_W) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^req_addr_i[ADDR_W-1:RC_W];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            beat_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            beat_q  <= beat_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state logic; tcnt holds the remaining cycles of the current wait state
    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        beat_d   = beat_q;
        we_d     = we_q;
        addr_d   = addr_q;
        accept_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_stb_i) begin
                    accept_c = 1'b1;
                    we_d     = req_we_i;
                    addr_d   = req_addr_i[RC_W-1:0];
                    beat_d   = '0;
`ifdef OPEN_PAGE_EN
                    if (!open_vld_q) begin
                        state_d = S_ACT;
                    end else if (open_row_q == req_addr_i[RC_W-1:COL_W]) begin
                        state_d = S_BURST;
                    end else begin
                        state_d = S_PRE;
                    end
`else
                    state_d = S_ACT;
`endif
                end
            end
            S_ACT: begin
                if (T_RCD == 1) begin
                    state_d = S_BURST;
                end else begin
                    state_d = S_RCD;
                    tcnt_d  = TCNT_W'(T_RCD - 1);
                end
            end
            S_RCD: begin
                if (tcnt_q == TCNT_W'(1)) state_d = S_BURST;
                else                      tcnt_d  = tcnt_q - TCNT_W'(1);
            end
            S_BURST: begin
                beat_d = beat_q + BEAT_W'(1);
                if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
                    if (we_q) begin
                        state_d = S_AFTER_DRAIN;
                    end else begin
                        state_d = S_DRAIN;
`ifdef OPEN_PAGE_EN
                        tcnt_d  = TCNT_W'(T_CAS + 1);
`else
                        tcnt_d  = TCNT_W'(T_CAS);
`endif
                    end
                end
            end
            S_DRAIN: begin
                if (tcnt_q == TCNT_W'(1)) state_d = S_AFTER_DRAIN;
                else                      tcnt_d  = tcnt_q - TCNT_W'(1);
            end
            S_PRE: begin
                if (T_RP == 1) begin
                    state_d = S_AFTER_RP;
                end else begin
                    state_d = S_RP;
                    tcnt_d  = TCNT_W'(T_RP - 1);
                end
            end
            S_RP: begin
                if (tcnt_q == TCNT_W'(1)) state_d = S_AFTER_RP;
                else                      tcnt_d  = tcnt_q - TCNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so every pin comes straight from a flop
    always_comb begin
        cmd_d       = CMD_DESEL;
        mem_addr_d  = '0;
        busy_d      = (state_d != S_IDLE);
        ack_d       = accept_c;
        wdata_rdy_d = 1'b0;
        dq_oe_d     = 1'b0;
        col_lo_c    = addr_d[BEAT_W-1:0] + beat_d;
        case (state_d)
            S_ACT: begin
                cmd_d      = CMD_ACT;
                mem_addr_d = MA_W'(addr_d[RC_W-1:COL_W]);
            end
            S_BURST: begin
                cmd_d       = we_d ? CMD_WRITE : CMD_READ;
                mem_addr_d  = MA_W'({addr_d[COL_W-1:BEAT_W], col_lo_c});
                wdata_rdy_d = we_d;
                dq_oe_d     = we_d;
            end
            S_RCD, S_DRAIN, S_RP: cmd_d = CMD_NOP;
            S_PRE:                cmd_d = CMD_PRE;
            default:              cmd_d = CMD_DESEL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            wdata_rdy_q <= 1'b0;
            dq_oe_q     <= 1'b0;
            cmd_q       <= CMD_DESEL;
            mem_addr_q  <= '0;
        end else begin
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            wdata_rdy_q <= wdata_rdy_d;
            dq_oe_q     <= dq_oe_d;
            cmd_q       <= cmd_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    // Read return: one pipe bit per READ, mem_dq_in captured T_CAS cycles later
    assign is_read_c = (state_q == S_BURST) && !we_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pipe_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_pipe_q  <= (rd_pipe_q << 1) | T_CAS'(is_read_c);
            rd_valid_q <= rd_pipe_q[T_CAS-1];
            if (rd_pipe_q[T_CAS-1]) rd_data_q <= mem_dq_in_i;
        end
    end

`ifdef OPEN_PAGE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_row_q <= '0;
            open_vld_q <= 1'b0;
        end else if (state_d == S_ACT) begin
            open_row_q <= addr_d[RC_W-1:COL_W];
            open_vld_q <= 1'b1;
        end
    end
`endif

    assign req_ack_o    = ack_q;
    assign busy_o       = busy_q;
    assign wdata_rdy_o  = wdata_rdy_q;
    assign mem_dq_oe_o  = dq_oe_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_cs_n_o   = cmd_q[3];
    assign mem_ras_n_o  = cmd_q[2];
    assign mem_cas_n_o  = cmd_q[1];
    assign mem_we_n_o   = cmd_q[0];
    assign rd_valid_o   = rd_valid_q;
    assign rd_data_o    = rd_data_q;
    assign mem_dq_out_o = dq_oe_q ? req_wdata_i : '0;

endmodule

// File: tb/tb_l2_mem_ctrl.sv
// Bench for l2_mem_ctrl in its default closed-page build: table vectors, random requests, held strobe, mid-burst reset.
module tb_l2_mem_ctrl;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int ROW_W  = 12;
    localparam int COL_W  = 10;
    localparam int BL     = 4;
    localparam int T_RCD  = 2;
    localparam int T_CAS  = 2;
    localparam int T_RP   = 2;
    localparam int MA_W   = 12;

    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_DES = 4'b1111;

    typedef struct packed {
        logic              ack;
        logic              busy;
        logic [3:0]        cmd;
        logic [MA_W-1:0]   maddr;
        logic              wrdy;
        logic              oe;
        logic              rdv;
        logic [DATA_W-1:0] dq_out;
        logic [DATA_W-1:0] rdata;
    } obs_t;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        int                exp_row;
        int                exp_col0;
        int                exp_pre;
        int                exp_idle;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic              req_stb;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ack;
    logic              busy;
    logic              wdata_rdy;
    logic [DATA_W-1:0] req_wdata;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [MA_W-1:0]   mem_addr;
    logic              mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n;
    logic [DATA_W-1:0] mem_dq_out;
    logic              mem_dq_oe;
    logic [DATA_W-1:0] mem_dq_in;

    int checks = 0;
    int errors = 0;

    l2_mem_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROW_W(ROW_W), .COL_W(COL_W),
        .BURST_LEN(BL), .T_RCD(T_RCD), .T_CAS(T_CAS), .T_RP(T_RP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_stb_i(req_stb), .req_we_i(req_we), .req_addr_i(req_addr),
        .req_ack_o(req_ack), .busy_o(busy), .wdata_rdy_o(wdata_rdy),
        .req_wdata_i(req_wdata), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .mem_addr_o(mem_addr), .mem_cs_n_o(mem_cs_n), .mem_ras_n_o(mem_ras_n),
        .mem_cas_n_o(mem_cas_n), .mem_we_n_o(mem_we_n),
        .mem_dq_out_o(mem_dq_out), .mem_dq_oe_o(mem_dq_oe), .mem_dq_in_i(mem_dq_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int col_of(int col, int k);
        return (col / BL) * BL + (col + k) % BL;
    endfunction

    function automatic logic [DATA_W-1:0] mdata(logic [31:0] salt, int row, int col);
        return {salt, 32'(row * 1024 + col)};
    endfunction

    function automatic logic [DATA_W-1:0] wdat(logic [31:0] salt, int k);
        return {~salt, 32'(k)};
    endfunction

    // Expected pins for cycle t of a request accepted with cycle 0 = ACT
    function automatic obs_t model(logic we, logic [ADDR_W-1:0] addr, int t, logic [31:0] salt);
        obs_t e;
        int row, col, p, idle, rv0;
        row  = int'((addr / 1024) % 4096);
        col  = int'(addr % 1024);
        p    = T_RCD + BL + (we ? 0 : T_CAS);
        idle = p + T_RP;
        rv0  = T_RCD + T_CAS + 1;
        e      = '0;
        e.ack  = (t == 0);
        e.busy = (t < idle);
        e.cmd  = (t < idle) ? C_NOP : C_DES;
        if (t == 0) begin
            e.cmd   = C_ACT;
            e.maddr = MA_W'(row);
        end else if (t >= T_RCD && t < T_RCD + BL) begin
            e.cmd   = we ? C_WR : C_RD;
            e.maddr = MA_W'(col_of(col, t - T_RCD));
            if (we) begin
                e.wrdy   = 1'b1;
                e.oe     = 1'b1;
                e.dq_out = wdat(salt, t - T_RCD);
            end
        end else if (t == p) begin
            e.cmd = C_PRE;
        end
        if (!we && t >= rv0 && t < rv0 + BL) begin
            e.rdv   = 1'b1;
            e.rdata = mdata(salt, row, col_of(col, t - rv0));
        end
        return e;
    endfunction

    function automatic obs_t sample(logic rdv_exp);
        obs_t g;
        g.ack    = req_ack;
        g.busy   = busy;
        g.cmd    = {mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n};
        g.maddr  = mem_addr;
        g.wrdy   = wdata_rdy;
        g.oe     = mem_dq_oe;
        g.rdv    = rd_valid;
        g.dq_out = mem_dq_out;
        g.rdata  = rdv_exp ? rd_data : '0;
        return g;
    endfunction

    task automatic check_obs(input string name, input int t, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%h exp=%h", name, t, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Issue one request from a negedge and check every cycle through the first idle cycle
    task automatic run_txn(input logic we, input logic [ADDR_W-1:0] addr, input bit hold,
                           output int o_row, output int o_col0, output int o_pre, output int o_idle);
        logic [31:0]       salt;
        logic [DATA_W-1:0] pend [0:63];
        bit                pv   [0:63];
        int                mrow, idle;
        obs_t              e, g;
        salt = $urandom;
        for (int i = 0; i < 64; i++) begin
            pv[i]   = 1'b0;
            pend[i] = '0;
        end
        idle   = T_RCD + BL + (we ? 0 : T_CAS) + T_RP;
        o_row  = -1;
        o_col0 = -1;
        o_pre  = -1;
        o_idle = -1;
        mrow   = 0;
        req_stb  = 1'b1;
        req_we   = we;
        req_addr = addr;
        for (int t = 0; t <= idle; t++) begin
            @(posedge clk);
            #1;
            req_wdata = (t >= T_RCD && t < T_RCD + BL) ? wdat(salt, t - T_RCD) : {$urandom, $urandom};
            mem_dq_in = pv[t] ? pend[t] : {$urandom, $urandom};
            @(negedge clk);
            e = model(we, addr, t, salt);
            g = sample(e.rdv);
            check_obs(we ? "wr_cycle" : "rd_cycle", t, g, e);
            if (g.cmd == C_ACT) mrow = int'(mem_addr);
            if (g.cmd == C_RD && t + T_CAS < 64) begin
                pend[t + T_CAS] = mdata(salt, mrow, int'(mem_addr));
                pv[t + T_CAS]   = 1'b1;
            end
            if (t == 0 && g.cmd == C_ACT) o_row = int'(mem_addr);
            if (t == T_RCD) o_col0 = int'(mem_addr);
            if (g.cmd == C_PRE && o_pre < 0) o_pre = t;
            if (!g.busy && o_idle < 0) o_idle = t;
            if (t == 0) begin
                if (!hold) req_stb = 1'b0;
                req_we   = 1'($urandom);
                req_addr = $urandom;
            end
        end
    endtask

    initial begin
        vec_t vt [5];
        obs_t rexp;
        int   r, c, p, i;

        vt[0] = '{1'b0, 32'h0000_1403, 5,    3,    8, 10};
        vt[1] = '{1'b1, 32'h0000_0800, 2,    0,    6,  8};
        vt[2] = '{1'b0, 32'h0000_0007, 0,    7,    8, 10};
        vt[3] = '{1'b1, 32'h003F_FFFF, 4095, 1023, 6,  8};
        vt[4] = '{1'b0, 32'hFFC0_0000, 0,    0,    8, 10};

        rexp     = '0;
        rexp.cmd = C_DES;

        rst_n     = 1'b0;
        req_stb   = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        mem_dq_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_obs("reset_state", 0, sample(1'b0), rexp);
        rst_n = 1'b1;
        @(negedge clk);
        check_obs("post_reset_idle", 0, sample(1'b0), rexp);

        for (int n = 0; n < 5; n++) begin
            run_txn(vt[n].we, vt[n].addr, 1'b0, r, c, p, i);
            check_int("act_row", r, vt[n].exp_row);
            check_int("first_col", c, vt[n].exp_col0);
            check_int("pre_cycle", p, vt[n].exp_pre);
            check_int("idle_cycle", i, vt[n].exp_idle);
        end

        // Strobe held through a request: second request is accepted only once busy drops
        run_txn(1'b0, 32'h0000_1403, 1'b1, r, c, p, i);
        check_int("held_idle_cycle", i, 10);
        run_txn(1'b1, 32'h0000_0800, 1'b0, r, c, p, i);
        check_int("held_second_row", r, 2);

        // Reset during cycle 3 of a read burst
        req_stb  = 1'b1;
        req_we   = 1'b0;
        req_addr = 32'h0000_1403;
        @(posedge clk);
        @(negedge clk);
        req_stb = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_obs("async_reset", 3, sample(1'b0), rexp);
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(posedge clk);
            #1;
            mem_dq_in = {$urandom, $urandom};
            @(negedge clk);
            check_obs("after_reset_quiet", t, sample(1'b0), rexp);
        end
        run_txn(1'b0, 32'h0000_1403, 1'b0, r, c, p, i);
        check_int("after_reset_pre", p, 8);

        // Random requests, some back-to-back with the strobe held
        for (int n = 0; n < 40; n++) begin
            bit hold;
            hold = (n != 39) && ($urandom_range(0, 3) == 0);
            run_txn(1'($urandom), $urandom, hold, r, c, p, i);
            if (!hold) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
